// File: rtl/pwm_bank.sv
// rtl/pwm_bank.sv - multi-channel PWM bank driven by a byte-stream command parser
module pwm_bank #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          data_in,
  input  logic                data_valid,
  input  logic                cs_n,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                cmd_err,
  output logic                busy
);

  // Bytes per duty write and last counter value before the wrap.
  localparam int NB = (WIDTH + 7) / 8;
  localparam logic [WIDTH-1:0] LAST = WIDTH'((1 << WIDTH) - 2);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic {IDLE, DATA} state_t;

  state_t      state, state_next;
  logic [1:0]  cnt, cnt_next;
  logic [6:0]  ch, ch_next;
  logic        is_en, is_en_next;
  logic [7:0]  prev_byte;
  logic        load_byte;
  logic        commit_duty;
  logic        commit_en;
  logic        err_next;

  // The duty word is the previous byte followed by the current one; only the
  // low WIDTH bits matter, so high bits of the first byte fall away.
  logic [15:0]      assembled;
  logic [WIDTH-1:0] duty_word;
  logic             unused_bits;

  assign assembled   = {prev_byte, data_in};
  assign duty_word   = assembled[WIDTH-1:0];
  assign unused_bits = ^assembled;
  assign busy        = (state == DATA);

  logic [PW-1:0]    psc;
  logic             tick;
  logic [WIDTH-1:0] count;
  logic             boundary;

  logic [WIDTH-1:0]    shadow_duty [CHANNELS];
  logic [WIDTH-1:0]    active_duty [CHANNELS];
  logic [CHANNELS-1:0] shadow_en;
  logic [CHANNELS-1:0] active_en;

  // Parser state register; cs_n high or reset drops any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ch        <= '0;
      is_en     <= 1'b0;
      prev_byte <= '0;
      cmd_err   <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      ch      <= ch_next;
      is_en   <= is_en_next;
      cmd_err <= err_next;
      if (load_byte) prev_byte <= data_in;
    end
  end

  // Parser next-state: opcode decode in IDLE, byte collection in DATA.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    ch_next     = ch;
    is_en_next  = is_en;
    load_byte   = 1'b0;
    commit_duty = 1'b0;
    commit_en   = 1'b0;
    err_next    = 1'b0;
    if (cs_n) begin
      state_next = IDLE;
    end else if (data_valid) begin
      case (state)
        IDLE: begin
          if (!data_in[7]) begin
            state_next = DATA;
            cnt_next   = 2'(NB);
            ch_next    = data_in[6:0];
            is_en_next = 1'b0;
          end else if (data_in == 8'h80) begin
            state_next = DATA;
            cnt_next   = 2'd1;
            is_en_next = 1'b1;
          end else begin
            err_next = 1'b1;
          end
        end
        DATA: begin
          load_byte = 1'b1;
          cnt_next  = cnt - 2'd1;
          if (cnt == 2'd1) begin
            state_next = IDLE;
            if (is_en) commit_en = 1'b1;
            else if (ch < 7'(CHANNELS)) commit_duty = 1'b1;
            else err_next = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign tick     = (psc == PW'(PRESCALE - 1));
  assign boundary = tick && (count == LAST);

  // Prescaler: one tick every PRESCALE clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) psc <= '0;
    else if (tick) psc <= '0;
    else psc <= psc + 1'b1;
  end

  // Period counter runs 0..2^WIDTH-2 so duty of all ones is constant high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count <= '0;
    else if (tick) count <= (count == LAST) ? '0 : count + 1'b1;
  end

  // Shadow registers take commits; active copies follow only at a boundary,
  // so a commit in the boundary cycle waits for the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_duty[i] <= '0;
        active_duty[i] <= '0;
      end
      shadow_en <= '1;
      active_en <= '1;
    end else begin
      if (boundary) begin
        for (int i = 0; i < CHANNELS; i++) active_duty[i] <= shadow_duty[i];
        active_en <= shadow_en;
      end
      if (commit_duty) begin
        for (int i = 0; i < CHANNELS; i++)
          if (ch == 7'(i)) shadow_duty[i] <= duty_word;
      end
      if (commit_en) shadow_en <= data_in[CHANNELS-1:0];
    end
  end

  // Registered compare of the counter against each active duty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm_out <= '0;
    else begin
      for (int i = 0; i < CHANNELS; i++)
        pwm_out[i] <= active_en[i] & (count < active_duty[i]);
    end
  end

endmodule

// File: tb/tb_pwm_bank.sv
// tb/tb_pwm_bank.sv - directed self-checking bench for pwm_bank
module tb_pwm_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       data_valid = 1'b0;
  logic       cs_n = 1'b0;
  int         sel = 0;

  logic       dv_a, dv_b, dv_c;
  logic [3:0] pwm_a, pwm_b, pwm_c;
  logic       err_a, err_b, err_c;
  logic       busy_a, busy_b, busy_c;

  assign dv_a = data_valid && (sel == 0);
  assign dv_b = data_valid && (sel == 1);
  assign dv_c = data_valid && (sel == 2);

  pwm_bank #(.CHANNELS(4), .WIDTH(8), .PRESCALE(1)) dut_a (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(dv_a), .cs_n(cs_n),
    .pwm_out(pwm_a), .cmd_err(err_a), .busy(busy_a));

  pwm_bank #(.CHANNELS(4), .WIDTH(12), .PRESCALE(1)) dut_b (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(dv_b), .cs_n(cs_n),
    .pwm_out(pwm_b), .cmd_err(err_b), .busy(busy_b));

  pwm_bank #(.CHANNELS(4), .WIDTH(8), .PRESCALE(3)) dut_c (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(dv_c), .cs_n(cs_n),
    .pwm_out(pwm_c), .cmd_err(err_c), .busy(busy_c));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int ecnt;
  int err_cnt [3] = '{0, 0, 0};
  int hc [4];

  // Edges since reset release; for dut_a the counter equals ecnt mod 255.
  always @(posedge clk or posedge rst) begin
    if (rst) ecnt <= 0;
    else ecnt <= ecnt + 1;
  end

  always @(negedge clk) begin
    if (err_a) err_cnt[0]++;
    if (err_b) err_cnt[1]++;
    if (err_c) err_cnt[2]++;
  end

  function automatic logic [3:0] pwm_of(input int s);
    if (s == 0) return pwm_a;
    if (s == 1) return pwm_b;
    return pwm_c;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input int s, input logic [7:0] b);
    sel = s;
    data_in = b;
    data_valid = 1'b1;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
  endtask

  task automatic count_win(input int s, input int n);
    logic [3:0] p;
    for (int c = 0; c < 4; c++) hc[c] = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      p = pwm_of(s);
      for (int c = 0; c < 4; c++) if (p[c]) hc[c]++;
    end
  endtask

  task automatic wait_phase(input int ph);
    int g = 0;
    while ((ecnt % 255) != ph && g < 600) begin
      step(1);
      g++;
    end
    n_cmp++;
    if ((ecnt % 255) != ph) begin
      n_bad++;
      $display("FAIL wait_phase: got phase %0d want %0d", ecnt % 255, ph);
    end
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    #20;
    n_cmp++;
    if ({pwm_a, pwm_b, pwm_c} !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_pwm: got %h want 000", {pwm_a, pwm_b, pwm_c});
    end
    n_cmp++;
    if ({err_a, err_b, err_c, busy_a, busy_b, busy_c} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 000000", {err_a, err_b, err_c, busy_a, busy_b, busy_c});
    end
    @(posedge clk);
    #1 rst = 1'b0;
    step(20);
    n_cmp++;
    if ({pwm_a, pwm_b, pwm_c} !== 12'h000) begin
      n_bad++;
      $display("FAIL post_reset_pwm: got %h want 000", {pwm_a, pwm_b, pwm_c});
    end
  endtask

  task automatic test_duty_basic;
    send_byte(0, 8'h01); send_byte(0, 8'h40);
    step(300); count_win(0, 255);
    n_cmp++;
    if (hc[1] != 64) begin n_bad++; $display("FAIL duty40_ch1: got %0d want 64", hc[1]); end
    n_cmp++;
    if (hc[0] + hc[2] + hc[3] != 0) begin
      n_bad++; $display("FAIL duty40_others: got %0d want 0", hc[0] + hc[2] + hc[3]);
    end
    send_byte(0, 8'h01); send_byte(0, 8'hFF);
    step(300); count_win(0, 255);
    n_cmp++;
    if (hc[1] != 255) begin n_bad++; $display("FAIL dutyFF_ch1: got %0d want 255", hc[1]); end
    send_byte(0, 8'h01); send_byte(0, 8'h00);
    step(300); count_win(0, 255);
    n_cmp++;
    if (hc[1] != 0) begin n_bad++; $display("FAIL duty00_ch1: got %0d want 0", hc[1]); end
  endtask

  task automatic test_mid_period;
    int rp = -1;
    wait_phase(100);
    send_byte(0, 8'h00); send_byte(0, 8'h80);
    for (int k = 0; k < 600; k++) begin
      step(1);
      if (pwm_a[0]) begin
        rp = ecnt % 255;
        break;
      end
    end
    n_cmp++;
    if (rp != 1) begin n_bad++; $display("FAIL mid_first_rise_phase: got %0d want 1", rp); end
    count_win(0, 255);
    n_cmp++;
    if (hc[0] != 128) begin n_bad++; $display("FAIL mid_duty80: got %0d want 128", hc[0]); end
  endtask

  task automatic test_boundary_commit;
    wait_phase(253);
    send_byte(0, 8'h00); send_byte(0, 8'h20);
    count_win(0, 255);
    n_cmp++;
    if (hc[0] != 128) begin n_bad++; $display("FAIL bnd_old_period: got %0d want 128", hc[0]); end
    count_win(0, 255);
    n_cmp++;
    if (hc[0] != 32) begin n_bad++; $display("FAIL bnd_new_period: got %0d want 32", hc[0]); end
  endtask

  task automatic test_back_to_back;
    send_byte(0, 8'h02); send_byte(0, 8'h10);
    send_byte(0, 8'h03); send_byte(0, 8'h20);
    step(300); count_win(0, 255);
    n_cmp++;
    if (hc[2] != 16) begin n_bad++; $display("FAIL b2b_ch2: got %0d want 16", hc[2]); end
    n_cmp++;
    if (hc[3] != 32) begin n_bad++; $display("FAIL b2b_ch3: got %0d want 32", hc[3]); end
  endtask

  task automatic test_errors;
    int e0;
    e0 = err_cnt[0];
    send_byte(0, 8'h05);
    n_cmp++;
    if (busy_a !== 1'b1) begin n_bad++; $display("FAIL badch_busy: got %b want 1", busy_a); end
    send_byte(0, 8'h33);
    step(3);
    n_cmp++;
    if (err_cnt[0] - e0 != 1) begin n_bad++; $display("FAIL badch_err_pulses: got %0d want 1", err_cnt[0] - e0); end
    n_cmp++;
    if (busy_a !== 1'b0) begin n_bad++; $display("FAIL badch_idle: got %b want 0", busy_a); end
    e0 = err_cnt[0];
    send_byte(0, 8'h90);
    step(3);
    n_cmp++;
    if (err_cnt[0] - e0 != 1) begin n_bad++; $display("FAIL op90_err_pulses: got %0d want 1", err_cnt[0] - e0); end
    n_cmp++;
    if (busy_a !== 1'b0) begin n_bad++; $display("FAIL op90_busy: got %b want 0", busy_a); end
    send_byte(0, 8'h01); send_byte(0, 8'h08);
    step(300); count_win(0, 255);
    n_cmp++;
    if (hc[1] != 8) begin n_bad++; $display("FAIL after_err_ch1: got %0d want 8", hc[1]); end
    n_cmp++;
    if (hc[0] != 32) begin n_bad++; $display("FAIL after_err_ch0: got %0d want 32", hc[0]); end
  endtask

  task automatic test_enable;
    send_byte(0, 8'h00); send_byte(0, 8'h40);
    send_byte(0, 8'h01); send_byte(0, 8'h00);
    send_byte(0, 8'h02); send_byte(0, 8'h00);
    send_byte(0, 8'h03); send_byte(0, 8'hC0);
    send_byte(0, 8'h80); send_byte(0, 8'h01);
    step(300); count_win(0, 255);
    n_cmp++;
    if (hc[0] != 64) begin n_bad++; $display("FAIL en01_ch0: got %0d want 64", hc[0]); end
    n_cmp++;
    if (hc[3] != 0) begin n_bad++; $display("FAIL en01_ch3: got %0d want 0", hc[3]); end
    send_byte(0, 8'h80); send_byte(0, 8'h0F);
    step(300); count_win(0, 255);
    n_cmp++;
    if (hc[3] != 192) begin n_bad++; $display("FAIL en0F_ch3: got %0d want 192", hc[3]); end
    n_cmp++;
    if (hc[0] != 64) begin n_bad++; $display("FAIL en0F_ch0: got %0d want 64", hc[0]); end
  endtask

  task automatic test_wide;
    int e0;
    send_byte(1, 8'h02); send_byte(1, 8'h0A); send_byte(1, 8'hBC);
    step(4200); count_win(1, 4095);
    n_cmp++;
    if (hc[2] != 2748) begin n_bad++; $display("FAIL w12_ch2: got %0d want 2748", hc[2]); end
    e0 = err_cnt[1];
    send_byte(1, 8'h02); send_byte(1, 8'h0A);
    n_cmp++;
    if (busy_b !== 1'b1) begin n_bad++; $display("FAIL w12_busy_mid: got %b want 1", busy_b); end
    cs_n = 1'b1;
    step(1);
    n_cmp++;
    if (busy_b !== 1'b0) begin n_bad++; $display("FAIL w12_abort_busy: got %b want 0", busy_b); end
    cs_n = 1'b0;
    step(2);
    n_cmp++;
    if (err_cnt[1] != e0) begin n_bad++; $display("FAIL w12_abort_err: got %0d want %0d", err_cnt[1], e0); end
    count_win(1, 4095);
    n_cmp++;
    if (hc[2] != 2748) begin n_bad++; $display("FAIL w12_abort_ch2: got %0d want 2748", hc[2]); end
  endtask

  task automatic test_prescale_reset;
    int found = 0;
    send_byte(2, 8'h00); send_byte(2, 8'h10);
    step(900); count_win(2, 765);
    n_cmp++;
    if (hc[0] != 48) begin n_bad++; $display("FAIL ps3_ch0: got %0d want 48", hc[0]); end
    send_byte(2, 8'h01);
    n_cmp++;
    if (busy_c !== 1'b1) begin n_bad++; $display("FAIL ps3_busy_mid: got %b want 1", busy_c); end
    for (int k = 0; k < 800; k++) begin
      if (pwm_c[0]) begin
        found = 1;
        break;
      end
      step(1);
    end
    n_cmp++;
    if (found != 1) begin n_bad++; $display("FAIL ps3_high_before_rst: got %0d want 1", found); end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({pwm_a, pwm_b, pwm_c, busy_c, err_c} !== 14'h0) begin
      n_bad++;
      $display("FAIL rst_async_clear: got %h want 0", {pwm_a, pwm_b, pwm_c, busy_c, err_c});
    end
    @(posedge clk);
    #1 rst = 1'b0;
    count_win(2, 765);
    n_cmp++;
    if (hc[0] != 0) begin n_bad++; $display("FAIL rst_duty_cleared: got %0d want 0", hc[0]); end
    send_byte(2, 8'h00); send_byte(2, 8'h10);
    step(900); count_win(2, 765);
    n_cmp++;
    if (hc[0] != 48) begin n_bad++; $display("FAIL rst_rewrite_ch0: got %0d want 48", hc[0]); end
  endtask

  initial begin
    test_reset;
    test_duty_basic;
    test_mid_period;
    test_boundary_commit;
    test_back_to_back;
    test_errors;
    test_enable;
    test_wide;
    test_prescale_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
